// File: rtl/alu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_pkg : ALUFun encodings and arbiter FSM state type                      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
package alu_pkg;

    localparam int          c_ALU_W   = 32;

    localparam logic [5:0]  c_FUN_ADD = 6'b000000;
    localparam logic [5:0]  c_FUN_SUB = 6'b000001;
    localparam logic [5:0]  c_FUN_AND = 6'b011000;
    localparam logic [5:0]  c_FUN_OR  = 6'b011110;
    localparam logic [5:0]  c_FUN_SLL = 6'b100000;
    localparam logic [5:0]  c_FUN_SRA = 6'b100011;
    localparam logic [5:0]  c_FUN_EQ  = 6'b110011;
    localparam logic [5:0]  c_FUN_LEZ = 6'b111101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu : combinational W-bit ALU; shifts move B by A[log2(W)-1:0]            |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module alu
    import alu_pkg::*;
#(
    parameter int W = c_ALU_W
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Sign,
    input  logic [5:0]   ALUFun,
    output logic [W-1:0] Z
);

    localparam int SHW = $clog2(W);

    logic [SHW-1:0] w_shamt;
    logic           w_a_zero;
    logic           w_lez;

    assign w_shamt  = A[SHW-1:0];
    assign w_a_zero = (A == '0);
    // Unsigned A can only be <= 0 when it is exactly zero
    assign w_lez    = Sign ? (A[W-1] | w_a_zero) : w_a_zero;

    always_comb begin
        Z = '0;
        case (ALUFun)
            c_FUN_ADD: Z = A + B;
            c_FUN_SUB: Z = A - B;
            c_FUN_AND: Z = A & B;
            c_FUN_OR:  Z = A | B;
            c_FUN_SLL: Z = B << w_shamt;
            c_FUN_SRA: Z = $signed(B) >>> w_shamt;
            c_FUN_EQ:  Z = {{(W-1){1'b0}}, (A == B)};
            c_FUN_LEZ: Z = {{(W-1){1'b0}}, w_lez};
            default:   Z = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_arbiter : two requesters share one ALU, one op in flight              |
// | Define ALU_ARB_FIXED_PRIO_EN for strict requester-0 priority (default RR) |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = c_ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic [W-1:0] i_a0,
    input  logic [W-1:0] i_b0,
    input  logic [W-1:0] i_a1,
    input  logic [W-1:0] i_b1,
    input  logic [5:0]   i_fun0,
    input  logic [5:0]   i_fun1,
    input  logic         i_sign0,
    input  logic         i_sign1,
    output logic [1:0]   o_rsp_valid,
    input  logic [1:0]   i_rsp_ready,
    output logic [W-1:0] o_rsp_z,
    output logic         o_busy
);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [5:0]     r_fun;
    logic           r_sign;
    logic           r_gnt;
    logic [W-1:0]   r_z;
    logic [W-1:0]   w_z;
    logic           w_gnt;
    logic           w_any;
    logic           w_accept;

    assign w_any    = |i_req_valid;
    assign w_accept = (r_state == ST_IDLE) && w_any;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_gnt = ~i_req_valid[0];
`else
    logic r_last;

    // On a tie the requester not served last wins; a lone requester always wins
    always_comb begin
        w_gnt = 1'b0;
        case (i_req_valid)
            2'b01:   w_gnt = 1'b0;
            2'b10:   w_gnt = 1'b1;
            2'b11:   w_gnt = ~r_last;
            default: w_gnt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_gnt;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (i_rsp_ready[r_gnt]) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_fun   <= '0;
            r_sign  <= 1'b0;
            r_gnt   <= 1'b0;
            r_z     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a    <= w_gnt ? i_a1    : i_a0;
                r_b    <= w_gnt ? i_b1    : i_b0;
                r_fun  <= w_gnt ? i_fun1  : i_fun0;
                r_sign <= w_gnt ? i_sign1 : i_sign0;
                r_gnt  <= w_gnt;
            end
            if (r_state == ST_EXEC) begin
                r_z <= w_z;
            end
        end
    end

    alu #(.W(W)) u_alu (
        .A      (r_a),
        .B      (r_b),
        .Sign   (r_sign),
        .ALUFun (r_fun),
        .Z      (w_z)
    );

    // Gated by rst_n so the accept strobe drops the moment reset asserts
    assign o_req_ready = (rst_n && w_accept) ? {w_gnt, ~w_gnt} : 2'b00;
    assign o_rsp_valid = (r_state == ST_RESP) ? {r_gnt, ~r_gnt} : 2'b00;
    assign o_rsp_z     = r_z;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_alu_arbiter : directed self-checking bench for alu_arbiter             |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   i_req_valid;
    logic [1:0]   o_req_ready;
    logic [W-1:0] i_a0, i_b0, i_a1, i_b1;
    logic [5:0]   i_fun0, i_fun1;
    logic         i_sign0, i_sign1;
    logic [1:0]   o_rsp_valid;
    logic [1:0]   i_rsp_ready;
    logic [W-1:0] o_rsp_z;
    logic         o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_a0        (i_a0),
        .i_b0        (i_b0),
        .i_a1        (i_a1),
        .i_b1        (i_b1),
        .i_fun0      (i_fun0),
        .i_fun1      (i_fun1),
        .i_sign0     (i_sign0),
        .i_sign1     (i_sign1),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_z     (o_rsp_z),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Issue from IDLE with rsp_ready high on both ports; valid held throughout
    task automatic run_txn(input string tag, input logic [1:0] valid,
                           input logic [1:0] exp_gnt, input logic [31:0] exp_z);
        i_req_valid = valid;
        i_rsp_ready = 2'b11;
        @(negedge clk);
        chk({tag, ".req_ready"}, {30'd0, o_req_ready}, {30'd0, exp_gnt});
        step();
        @(negedge clk);
        chk({tag, ".exec_rdy"},  {30'd0, o_req_ready}, 32'd0);
        chk({tag, ".exec_busy"}, {31'd0, o_busy}, 32'd1);
        chk({tag, ".exec_vld"},  {30'd0, o_rsp_valid}, 32'd0);
        step();
        @(negedge clk);
        chk({tag, ".rsp_valid"}, {30'd0, o_rsp_valid}, {30'd0, exp_gnt});
        chk({tag, ".rsp_z"},     o_rsp_z, exp_z);
        step();
    endtask

    initial begin
        i_a0 = '0; i_b0 = '0; i_a1 = '0; i_b1 = '0;
        i_fun0 = c_FUN_ADD; i_fun1 = c_FUN_ADD;
        i_sign0 = 1'b0; i_sign1 = 1'b0;
        do_reset();

        @(negedge clk);
        chk("rst.busy",      {31'd0, o_busy}, 32'd0);
        chk("rst.rsp_valid", {30'd0, o_rsp_valid}, 32'd0);
        chk("rst.rsp_z",     o_rsp_z, 32'd0);
        chk("rst.req_ready", {30'd0, o_req_ready}, 32'd0);
        step();

        // Single requester 0: 1 + 2
        i_a0 = 32'd1; i_b0 = 32'd2; i_fun0 = c_FUN_ADD;
        run_txn("add0", 2'b01, 2'b01, 32'd3);
        i_req_valid = 2'b00;
        @(negedge clk);
        chk("add0.idle_busy", {31'd0, o_busy}, 32'd0);
        step();

        // Tie straight after reset, then back-to-back alternation
        do_reset();
        i_a0 = 32'd5; i_b0 = 32'd3; i_fun0 = c_FUN_SUB;
        i_a1 = 32'h8000_0005; i_b1 = 32'h8000_0003; i_fun1 = c_FUN_AND;
`ifdef ALU_ARB_FIXED_PRIO_EN
        run_txn("tie1", 2'b11, 2'b01, 32'd2);
        run_txn("tie2", 2'b11, 2'b01, 32'd2);
        run_txn("tie3", 2'b11, 2'b01, 32'd2);
        run_txn("tie4", 2'b11, 2'b01, 32'd2);
`else
        run_txn("tie1", 2'b11, 2'b01, 32'd2);
        run_txn("tie2", 2'b11, 2'b10, 32'h8000_0001);
        run_txn("tie3", 2'b11, 2'b01, 32'd2);
        run_txn("tie4", 2'b11, 2'b10, 32'h8000_0001);
`endif
        // Lone requester 1 wins even though it was served last
        run_txn("solo1", 2'b10, 2'b10, 32'h8000_0001);

        // Requester 1 SRA with a 5-cycle response stall
        i_a1 = 32'd4; i_b1 = 32'h7FFF_FFFF; i_sign1 = 1'b1; i_fun1 = c_FUN_SRA;
        i_req_valid = 2'b10;
        i_rsp_ready = 2'b01;
        @(negedge clk);
        chk("sra.req_ready", {30'd0, o_req_ready}, 32'd2);
        step();
        i_req_valid = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.rsp_valid", {30'd0, o_rsp_valid}, 32'd2);
            chk("stall.rsp_z",     o_rsp_z, 32'h07FF_FFFF);
            chk("stall.req_ready", {30'd0, o_req_ready}, 32'd0);
            chk("stall.busy",      {31'd0, o_busy}, 32'd1);
            step();
        end
        i_rsp_ready = 2'b10;
        step();
        @(negedge clk);
        chk("stall.idle_busy",  {31'd0, o_busy}, 32'd0);
        chk("stall.idle_rdy",   {30'd0, o_req_ready}, 32'd1);
        chk("stall.hold_z",     o_rsp_z, 32'h07FF_FFFF);
        chk("stall.idle_vld",   {30'd0, o_rsp_valid}, 32'd0);
        i_req_valid = 2'b00;
        step();

        // Compare and shift functions
        i_a1 = 32'h8000_0001; i_b1 = 32'h8000_0001; i_fun1 = c_FUN_EQ;
        run_txn("eq1", 2'b10, 2'b10, 32'd1);
        i_a0 = 32'hFFFF_FFFF; i_sign0 = 1'b1; i_fun0 = c_FUN_LEZ;
        run_txn("lez_s", 2'b01, 2'b01, 32'd1);
        i_sign0 = 1'b0;
        run_txn("lez_u", 2'b01, 2'b01, 32'd0);
        i_a0 = 32'd4; i_b0 = 32'd1; i_fun0 = c_FUN_SLL;
        run_txn("sll0", 2'b01, 2'b01, 32'd16);
        i_a0 = 32'h0000_F000; i_b0 = 32'h0000_000F; i_fun0 = c_FUN_OR;
        run_txn("or0", 2'b01, 2'b01, 32'h0000_F00F);

        // Reset asserted during EXEC aborts the operation
        i_a0 = 32'd7; i_b0 = 32'd8; i_fun0 = c_FUN_ADD;
        i_req_valid = 2'b01;
        i_rsp_ready = 2'b11;
        step();
        @(negedge clk);
        chk("abort.in_exec", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy",      {31'd0, o_busy}, 32'd0);
        chk("abort.rsp_valid", {30'd0, o_rsp_valid}, 32'd0);
        chk("abort.rsp_z",     o_rsp_z, 32'd0);
        chk("abort.req_ready", {30'd0, o_req_ready}, 32'd0);
        i_req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort.post_vld",  {30'd0, o_rsp_valid}, 32'd0);
            chk("abort.post_busy", {31'd0, o_busy}, 32'd0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
